// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding,
// L/E/G result layout and a small sizing helper.
package seq_mag_comparator_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Result bits are always ordered {L, E, G}.
   typedef struct packed {
      logic l;
      logic e;
      logic g;
   } res_t;

   localparam res_t RES_NONE = 3'b000;
   localparam res_t RES_LT   = 3'b100;
   localparam res_t RES_EQ   = 3'b010;
   localparam res_t RES_GT   = 3'b001;

   // Index register width; a single-digit compare still needs a 1-bit register.
   function automatic int unsigned idx_width(input int unsigned ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational DIGIT-bit magnitude comparator; the generalised form of the
// original 2-bit L/E/G comparator.
module digit_cmp #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   // Scan MSB-first; the first differing bit decides the order.
   always_comb begin
      lt = 1'b0;
      gt = 1'b0;
      for (int i = int'(DIGIT) - 1; i >= 0; i--) begin
         if (!lt && !gt) begin
            if (a[i] && !b[i]) begin
               gt = 1'b1;
            end else if (!a[i] && b[i]) begin
               lt = 1'b1;
            end
         end
      end
      eq = !lt && !gt;
   end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first
// differing digit, unsigned or two's-complement, start/busy/done handshake.
module seq_mag_comparator
   import seq_mag_comparator_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             L,
   output logic             E,
   output logic             G
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned IW   = idx_width(NDIG);

   localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
   localparam logic [IW-1:0]    IDX_TOP   = IW'(NDIG - 1);

   state_t          state_q;
   logic [IW-1:0]   idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   res_t            res_q;
   logic            done_q;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic             dig_lt;
   logic             dig_eq;
   logic             dig_gt;

   assign a_dig = a_q[idx_q*DIGIT +: DIGIT];
   assign b_dig = b_q[idx_q*DIGIT +: DIGIT];

   digit_cmp #(
      .DIGIT (DIGIT)
   ) u_digit_cmp (
      .a  (a_dig),
      .b  (b_dig),
      .lt (dig_lt),
      .eq (dig_eq),
      .gt (dig_gt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= RES_NONE;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  // Flipping the sign bits maps signed order onto unsigned order.
                  a_q     <= signed_mode ? (A ^ SIGN_MASK) : A;
                  b_q     <= signed_mode ? (B ^ SIGN_MASK) : B;
                  idx_q   <= IDX_TOP;
                  res_q   <= RES_NONE;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (dig_gt) begin
                  res_q   <= RES_GT;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (dig_lt) begin
                  res_q   <= RES_LT;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (dig_eq && (idx_q == '0)) begin
                  res_q   <= RES_EQ;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign L    = res_q.l;
   assign E    = res_q.e;
   assign G    = res_q.g;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboarded bench: an 8-bit/2-bit-digit comparator driven from a vector
// table and hand sequences, plus an exhaustive 2-bit/1-bit-digit instance.
module tb_seq_mag_comparator;

   localparam logic [2:0] X_LT = 3'b100;
   localparam logic [2:0] X_EQ = 3'b010;
   localparam logic [2:0] X_GT = 3'b001;

   typedef struct {
      logic [2:0] res;
      int         lat;
      int         t0;
   } sb_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sm;
      logic [2:0] res;
      int         lat;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start8, sm8, busy8, done8, l8, e8, g8;
   logic [7:0] a8, b8;
   logic       start2, sm2, busy2, done2, l2, e2, g2;
   logic [1:0] a2, b2;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   sb_t q8[$];
   sb_t q2[$];
   sb_t e8x, e2x;

   seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .L(l8), .E(e8), .G(g8)
   );

   seq_mag_comparator #(.WIDTH(2), .DIGIT(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .L(l2), .E(e2), .G(g2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard monitors: pop on every done, and check L/E/G stay clear while busy.
   always @(negedge clk) begin
      if (done8) begin
         if (q8.size() == 0) begin
            tests++; fails++;
            $display("FAIL d8_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
         end else begin
            e8x = q8.pop_front();
            chk("d8_result", {29'd0, l8, e8, g8}, {29'd0, e8x.res});
            chk("d8_latency", cyc - e8x.t0, e8x.lat);
         end
      end else if (busy8) begin
         chk("d8_leg_clear_while_busy", {29'd0, l8, e8, g8}, 0);
      end
   end

   always @(negedge clk) begin
      if (done2) begin
         if (q2.size() == 0) begin
            tests++; fails++;
            $display("FAIL d2_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
         end else begin
            e2x = q2.pop_front();
            chk("d2_result", {29'd0, l2, e2, g2}, {29'd0, e2x.res});
            chk("d2_latency", cyc - e2x.t0, e2x.lat);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive a start on the next negedge; expectation is queued once the edge accepts it.
   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [2:0] res, input int lat);
      @(negedge clk);
      a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      q8.push_back('{res: res, lat: lat, t0: cyc});
      chk("d8_busy_after_start", {31'd0, busy8}, 1);
   endtask

   task automatic go2(input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] res, input int lat);
      @(negedge clk);
      a2 = a; b2 = b; sm2 = 1'b0; start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      q2.push_back('{res: res, lat: lat, t0: cyc});
   endtask

   task automatic drain8();
      for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
      if (q8.size() != 0) begin
         tests++; fails++;
         $display("FAIL d8_timeout: got no done within 40 cycles, expected done");
         q8.delete();
      end
   endtask

   task automatic drain2();
      for (int i = 0; i < 40 && q2.size() != 0; i++) @(negedge clk);
      if (q2.size() != 0) begin
         tests++; fails++;
         $display("FAIL d2_timeout: got no done within 40 cycles, expected done");
         q2.delete();
      end
   endtask

   vec_t vecs[9];

   initial begin
      int seen;
      logic [2:0] r;
      logic [1:0] va, vb;

      vecs[0] = '{a: 8'hA5, b: 8'hA5, sm: 1'b0, res: X_EQ, lat: 4};
      vecs[1] = '{a: 8'h80, b: 8'h7F, sm: 1'b0, res: X_GT, lat: 1};
      vecs[2] = '{a: 8'h80, b: 8'h7F, sm: 1'b1, res: X_LT, lat: 1};
      vecs[3] = '{a: 8'h12, b: 8'h13, sm: 1'b0, res: X_LT, lat: 4};
      vecs[4] = '{a: 8'hF0, b: 8'h0F, sm: 1'b0, res: X_GT, lat: 1};
      vecs[5] = '{a: 8'h7F, b: 8'h80, sm: 1'b1, res: X_GT, lat: 1};
      vecs[6] = '{a: 8'hFF, b: 8'hFE, sm: 1'b1, res: X_GT, lat: 4};
      vecs[7] = '{a: 8'h00, b: 8'h00, sm: 1'b1, res: X_EQ, lat: 4};
      vecs[8] = '{a: 8'h3C, b: 8'h34, sm: 1'b0, res: X_GT, lat: 3};

      rst = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;

      do_reset();
      chk("reset_busy", {31'd0, busy8}, 0);
      chk("reset_done", {31'd0, done8}, 0);
      chk("reset_leg", {29'd0, l8, e8, g8}, 0);
      chk("reset_d2_outputs", {27'd0, busy2, done2, l2, e2, g2}, 0);

      foreach (vecs[i]) begin
         do_reset();
         go8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].lat);
         drain8();
      end

      // Back-to-back: a new start issued in the done cycle is accepted.
      do_reset();
      go8(8'h12, 8'h13, 1'b0, X_LT, 4);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (done8) seen = 1;
      end
      chk("b2b_done_seen", seen, 1);
      a8 = 8'hF0; b8 = 8'h0F; sm8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      q8.push_back('{res: X_GT, lat: 1, t0: cyc});
      chk("b2b_done_dropped", {31'd0, done8}, 0);
      chk("b2b_busy_rose", {31'd0, busy8}, 1);
      chk("b2b_leg_cleared", {29'd0, l8, e8, g8}, 0);
      drain8();
      // Idle with start low: the last result is held.
      repeat (3) @(negedge clk);
      chk("idle_hold_result", {29'd0, l8, e8, g8}, {29'd0, X_GT});
      chk("idle_not_busy", {31'd0, busy8}, 0);

      // Start during RUN is ignored; reset mid-compare aborts with no done.
      do_reset();
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h01; sm8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1;
      @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("ignored_start_still_busy", {31'd0, busy8}, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, busy8}, 0);
      chk("abort_done", {31'd0, done8}, 0);
      chk("abort_leg", {29'd0, l8, e8, g8}, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done8) seen = 1;
      end
      chk("abort_no_done", seen, 0);

      // Exhaustive 2-bit unsigned compare, one bit per cycle.
      do_reset();
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            va = 2'(a);
            vb = 2'(b);
            r = (a < b) ? X_LT : ((a == b) ? X_EQ : X_GT);
            go2(va, vb, r, (va[1] != vb[1]) ? 1 : 2);
            drain2();
         end
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1);
   end

endmodule
